// File: rtl/gray_arb_pkg.sv
// Shared types and defaults for the round-robin Gray-code conversion arbiter.
package gray_arb_pkg;

  localparam int W_DEF    = 8;
  localparam int NREQ_DEF = 4;

  typedef enum logic {
    MODE_B2G = 1'b0,
    MODE_G2B = 1'b1
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_e;

endpackage

// File: rtl/gray_conv_unit.sv
// Combinational binary<->Gray converter shared by all requesters.
module gray_conv_unit
  import gray_arb_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] data_in,
  input  mode_e        mode,
  output logic [W-1:0] data_out
);

  function automatic logic [W-1:0] bin2gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the running XOR of all Gray bits at and above it.
  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int k = W - 2; k >= 0; k--) begin
      b[k] = b[k+1] ^ g[k];
    end
    return b;
  endfunction

  always_comb begin
    data_out = (mode == MODE_G2B) ? gray2bin(data_in) : bin2gray(data_in);
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter feeding one shared Gray converter into a single output register.
module gray_conv_arbiter
  import gray_arb_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int NREQ = NREQ_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*W-1:0]        req_data,
  input  logic [NREQ-1:0]          req_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_data,
  output logic [$clog2(NREQ)-1:0]  out_id,
  output logic                     out_mode,
  output logic [15:0]              conv_count
);

  localparam int IDW = $clog2(NREQ);

  state_e           state_q, state_d;
  logic [IDW-1:0]   last_grant_q;
  logic [IDW-1:0]   grant_idx_p0;
  logic             grant_any_p0;
  logic             out_free;
  logic             req_xfer;
  logic             out_xfer;
  logic [W-1:0]     sel_data_p0;
  logic             sel_mode_p0;
  logic [W-1:0]     conv_data_p0;

  assign out_valid = (state_q == FULL);
  assign out_free  = !out_valid || out_ready;
  assign out_xfer  = out_valid && out_ready;

  // Search only looks at req_valid and last_grant so req_ready never sees data or mode.
  always_comb begin
    int unsigned idx;
    grant_any_p0 = 1'b0;
    grant_idx_p0 = '0;
    idx          = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant_q) + k) % NREQ;
      if (!grant_any_p0 && req_valid[idx]) begin
        grant_any_p0 = 1'b1;
        grant_idx_p0 = idx[IDW-1:0];
      end
    end
  end

  assign req_ready = (rst_n && grant_any_p0 && out_free) ? (NREQ'(1) << grant_idx_p0) : '0;
  assign req_xfer  = |(req_valid & req_ready);

  assign sel_data_p0 = req_data[grant_idx_p0*W +: W];
  assign sel_mode_p0 = req_mode[grant_idx_p0];

  gray_conv_unit #(
    .W (W)
  ) u_conv (
    .data_in  (sel_data_p0),
    .mode     (mode_e'(sel_mode_p0)),
    .data_out (conv_data_p0)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_xfer) state_d = FULL;
      FULL:    if (out_ready && !req_xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p0 -> p1: grant, converted word and bookkeeping registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= IDW'(NREQ - 1);
      out_data     <= '0;
      out_id       <= '0;
      out_mode     <= 1'b0;
      conv_count   <= '0;
    end else begin
      state_q <= state_d;
      if (req_xfer) begin
        last_grant_q <= grant_idx_p0;
        out_data     <= conv_data_p0;
        out_id       <= grant_idx_p0;
        out_mode     <= sel_mode_p0;
      end
      if (out_xfer && (conv_count != 16'hFFFF)) begin
        conv_count <= conv_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed bench for gray_conv_arbiter with immediate-assertion checks.
module tb_gray_conv_arbiter;

  localparam int W    = 8;
  localparam int NREQ = 4;

  logic             clk;
  logic             rst_n;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  req_ready;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]  req_mode;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [1:0]       out_id;
  logic             out_mode;
  logic [15:0]      conv_count;

  int total;
  int passed;

  gray_conv_arbiter #(.W(W), .NREQ(NREQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_mode   (req_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_id     (out_id),
    .out_mode   (out_mode),
    .conv_count (conv_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_req(input int i, input logic [7:0] d, input logic m);
    req_data[i*W +: W] = d;
    req_mode[i]        = m;
  endtask

  logic [1:0] fair_id   [8] = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
  logic [7:0] fair_data [8] = '{8'h29, 8'h01, 8'h19, 8'h31, 8'h29, 8'h01, 8'h19, 8'h31};

  initial begin
    total     = 0;
    passed    = 0;
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_data  = '0;
    req_mode  = '0;
    out_ready = 1'b0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_id", 32'(out_id), 32'h0);
    check("rst_count", 32'(conv_count), 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h0);

    @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b1;

    // single request, binary to Gray
    @(negedge clk);
    set_req(0, 8'hB4, 1'b0);
    req_valid = 4'b0001;
    out_ready = 1'b1;
    #1 check("single_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    check("single_valid", 32'(out_valid), 32'h1);
    check("single_data", 32'(out_data), 32'hEE);
    check("single_id", 32'(out_id), 32'h0);
    check("single_mode", 32'(out_mode), 32'h0);
    req_valid = '0;
    @(negedge clk);
    check("single_drain_valid", 32'(out_valid), 32'h0);
    check("single_count", 32'(conv_count), 32'h1);

    // inverse conversion then back-to-back forward conversion on req2
    set_req(2, 8'hEE, 1'b1);
    req_valid = 4'b0100;
    #1 check("inv_ready", 32'(req_ready), 32'h4);
    @(negedge clk);
    check("inv_data", 32'(out_data), 32'hB4);
    check("inv_id", 32'(out_id), 32'h2);
    check("inv_mode", 32'(out_mode), 32'h1);
    set_req(2, 8'hFF, 1'b0);
    #1 check("b2b_ready", 32'(req_ready), 32'h4);
    @(negedge clk);
    check("ff_data", 32'(out_data), 32'h80);
    check("ff_mode", 32'(out_mode), 32'h0);
    check("b2b_count", 32'(conv_count), 32'h2);
    req_valid = '0;
    @(negedge clk);
    check("inv_count", 32'(conv_count), 32'h3);

    // fairness: last grant was 2, so rotation starts at 3
    set_req(0, 8'h01, 1'b0);
    set_req(1, 8'h11, 1'b0);
    set_req(2, 8'h21, 1'b0);
    set_req(3, 8'h31, 1'b0);
    req_valid = 4'hF;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      check($sformatf("fair_valid_%0d", j), 32'(out_valid), 32'h1);
      check($sformatf("fair_id_%0d", j), 32'(out_id), 32'(fair_id[j]));
      check($sformatf("fair_data_%0d", j), 32'(out_data), 32'(fair_data[j]));
    end
    req_valid = '0;
    @(negedge clk);
    check("fair_drain_valid", 32'(out_valid), 32'h0);
    check("fair_count", 32'(conv_count), 32'd11);

    // backpressure on a result from req1
    req_valid = 4'b0010;
    out_ready = 1'b0;
    #1 check("bp_ready_idle", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = 4'hF;
    for (int j = 0; j < 5; j++) begin
      #1;
      check($sformatf("bp_ready_%0d", j), 32'(req_ready), 32'h0);
      check($sformatf("bp_data_%0d", j), 32'(out_data), 32'h19);
      check($sformatf("bp_id_%0d", j), 32'(out_id), 32'h1);
      check($sformatf("bp_count_%0d", j), 32'(conv_count), 32'd11);
      @(negedge clk);
    end
    out_ready = 1'b1;
    req_valid = '0;
    @(negedge clk);
    check("bp_release_count", 32'(conv_count), 32'd12);
    check("bp_release_valid", 32'(out_valid), 32'h0);

    // reset while holding a stalled result
    set_req(0, 8'hB4, 1'b0);
    req_valid = 4'b0001;
    out_ready = 1'b0;
    @(negedge clk);
    check("mid_full", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_data", 32'(out_data), 32'h0);
    check("mid_rst_count", 32'(conv_count), 32'h0);
    check("mid_rst_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    req_valid = 4'b1001;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1 check("post_rst_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    check("post_rst_id", 32'(out_id), 32'h0);
    check("post_rst_data", 32'(out_data), 32'hEE);
    req_valid = '0;
    @(negedge clk);
    check("post_rst_count", 32'(conv_count), 32'h1);

    // counter saturation
    force dut.conv_count = 16'hFFFE;
    #1 release dut.conv_count;
    #1 check("sat_preload", 32'(conv_count), 32'hFFFE);
    req_valid = 4'b0001;
    @(negedge clk);
    check("sat_first", 32'(conv_count), 32'hFFFE);
    @(negedge clk);
    check("sat_reach", 32'(conv_count), 32'hFFFF);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    check("sat_hold", 32'(conv_count), 32'hFFFF);
    check("sat_drain_valid", 32'(out_valid), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/gray_conv_arbiter.md
GRAY_CONV_ARBITER -- requirements
Module: gray_conv_arbiter

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the code word width in bits.
REQ-002 The block SHALL have parameter NREQ, default 4, giving the number of requesters; the legal range is 2..8.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with the port list below.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept
- req_data  in  NREQ*W  per-requester word; requester i occupies bits [i*W +: W]
- req_mode  in  NREQ  per-requester mode: 0 = binary to Gray, 1 = Gray to binary
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_data  out  W  converted word
- out_id  out  clog2(NREQ)  index of the requester that produced the result
- out_mode  out  1  mode used for the result
- conv_count  out  16  number of completed output transfers, saturating

Function
REQ-004 The block SHALL share one conversion datapath between all requesters, accepting at most one request per cycle.
REQ-005 A transfer SHALL occur on a request port when req_valid[i] and req_ready[i] are both high at a rising clk edge; an output transfer SHALL occur when out_valid and out_ready are both high.
REQ-006 The block SHALL assert at most one req_ready bit per cycle.
- That bit SHALL be the round-robin grant.
- It SHALL be asserted only when the output register is free, meaning out_valid is low, or out_valid and out_ready are both high.
REQ-007 Round-robin search SHALL start at the index after last_grant and wrap from NREQ-1 to 0.
- last_grant SHALL update only when a request transfer occurs.
- A requester with req_valid low SHALL be skipped with no cycle penalty.
REQ-008 Binary to Gray conversion SHALL be g[W-1] = b[W-1] and g[k] = b[k+1] XOR b[k] for k < W-1.
REQ-009 Gray to binary conversion SHALL be b[W-1] = g[W-1] and b[k] = b[k+1] XOR g[k].
REQ-010 Latency SHALL be exactly one cycle: a request accepted at edge N SHALL present out_valid, out_data, out_id and out_mode after edge N.
REQ-011 The FSM SHALL have exactly two states, IDLE (output register empty) and FULL (out_valid high).
- IDLE goes to FULL on a request transfer.
- FULL stays in FULL on an output transfer with a simultaneous request transfer (back-to-back, one word per cycle).
- FULL goes to IDLE on an output transfer with no request transfer.
- FULL stays in FULL while out_ready is low.
REQ-012 While out_valid is high and out_ready is low, out_data, out_id and out_mode SHALL remain stable and all req_ready bits SHALL be low.
REQ-013 conv_count SHALL increment by 1 on each output transfer and SHALL saturate at 16'hFFFF with no wrap-around.
REQ-014 req_ready SHALL NOT depend combinationally on req_data or req_mode.

Reset
REQ-015 Asserting rst_n low SHALL immediately force the following values, regardless of clk:
- state = IDLE, out_valid = 0, out_data = 0, out_id = 0, out_mode = 0
- conv_count = 0, last_grant = NREQ-1 (so requester 0 has first priority)
- all req_ready bits = 0
REQ-016 A reset asserted mid-operation SHALL discard any held result with no output transfer.
REQ-017 After rst_n deasserts, the first grant SHALL be possible at the first clk edge.

Structure
REQ-018 Package gray_arb_pkg SHALL hold:
- the W and NREQ defaults
- the mode enum (MODE_B2G = 0, MODE_G2B = 1)
- the FSM state enum (IDLE, FULL)
REQ-019 The conversion datapath SHALL be a purely combinational sub-module, gray_conv_unit, with ports data_in, mode and data_out, instantiated once.
REQ-020 The grant logic, FSM, output register and counter SHALL reside in gray_conv_arbiter.

Verification
REQ-021 Single request: req0 valid, data 8'hB4, mode 0 -> next cycle out_data = 8'hEE, out_id = 0, out_mode = 0.
REQ-022 Inverse conversion: req2 valid, data 8'hEE, mode 1 -> out_data = 8'hB4, out_id = 2; also data 8'hFF, mode 0 -> out_data = 8'h80.
REQ-023 Fairness: all four requesters continuously valid with out_ready = 1 -> out_id sequence 0,1,2,3,0,... with out_valid high every cycle after the first.
REQ-024 Backpressure: out_ready held low for 5 cycles while out_valid is high -> out_data and out_id stable, all req_ready bits low, conv_count unchanged; on release, exactly one increment.
REQ-025 Reset mid-operation: rst_n pulsed low while in FULL with out_ready low -> out_valid = 0 immediately; after release, with req3 and req0 both valid, the grant goes to req0.
REQ-026 Saturation: conv_count preloaded via force to 16'hFFFE, then 3 output transfers -> conv_count = 16'hFFFF.
